// File: rtl/video_out_fmt_pkg.sv
// Shared data types for the video output formatter.
//   sl_mode_e   : scanline darkening level applied to odd lines.
//   VgaSignal_t : sync and display-enable bundle carried through the pipeline.
package video_out_fmt_pkg;

  typedef enum logic [1:0] {
    SlOff = 2'd0,  // no darkening
    Sl75  = 2'd1,  // 75% level
    Sl50  = 2'd2,  // 50% level
    Sl25  = 2'd3   // 25% level
  } sl_mode_e;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } VgaSignal_t;

endpackage

// File: rtl/video_out_fmt_chan_expand.sv
// One colour channel: widen by MSB-first bit replication, blank outside the
// active area and apply scanline darkening.
// Ports:
//   color_i [IN_W]  : delayed input colour
//   de_i            : delayed display enable (0 forces output to 0)
//   dark_i          : darkening level for this pixel (SlOff = none)
//   color_o [OUT_W] : expanded channel value
module video_out_fmt_chan_expand
  import video_out_fmt_pkg::*;
#(
  parameter int unsigned IN_W  = 3,
  parameter int unsigned OUT_W = 8
) (
  input  logic [IN_W-1:0]  color_i,
  input  logic             de_i,
  input  sl_mode_e         dark_i,
  output logic [OUT_W-1:0] color_o
);

  logic [OUT_W-1:0] expanded;

  // Output bit i (counting from the MSB) takes input bit (i mod IN_W) from the MSB.
  for (genvar i = 0; i < OUT_W; i++) begin : g_rep
    assign expanded[OUT_W-1-i] = color_i[IN_W-1-(i%IN_W)];
  end

  always_comb begin
    color_o = '0;
    if (de_i) begin
      unique case (dark_i)
        SlOff:   color_o = expanded;
        Sl75:    color_o = expanded - (expanded >> 2);
        Sl50:    color_o = expanded >> 1;
        Sl25:    color_o = expanded >> 2;
        default: color_o = expanded;
      endcase
    end
  end

endmodule

// File: rtl/video_out_fmt.sv
// Video output formatter: delays colour and syncs by PIPE pixel-enabled cycles,
// expands colour to OUT_W bits, blanks outside DE, adjusts sync polarity and
// darkens odd lines according to a per-frame scanline mode.
// Ports:
//   clk_sys, rst_n (async, active low), ce_pix (pixel enable)
//   r_in/g_in/b_in [IN_W], hs_in, vs_in (active high), de_in, sl_mode [2]
//   VGA_R/VGA_G/VGA_B [OUT_W], VGA_HS, VGA_VS, VGA_DE
//   line_odd  : undelayed line parity (cleared at frame start)
//   frame_cnt : frames since reset, wrapping
module video_out_fmt
  import video_out_fmt_pkg::*;
#(
  parameter int unsigned IN_W   = 3,
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned PIPE   = 2,
  parameter bit          HS_POL = 1'b0,
  parameter bit          VS_POL = 1'b0
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             ce_pix,
  input  logic [IN_W-1:0]  r_in,
  input  logic [IN_W-1:0]  g_in,
  input  logic [IN_W-1:0]  b_in,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic             de_in,
  input  logic [1:0]       sl_mode,
  output logic [OUT_W-1:0] VGA_R,
  output logic [OUT_W-1:0] VGA_G,
  output logic [OUT_W-1:0] VGA_B,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             VGA_DE,
  output logic             line_odd,
  output logic [15:0]      frame_cnt
);

  typedef struct packed {
    logic [IN_W-1:0] r;
    logic [IN_W-1:0] g;
    logic [IN_W-1:0] b;
    VgaSignal_t      sig;
    sl_mode_e        dark;
  } stage_t;

  logic     hs_prev_q, vs_prev_q;
  logic     line_odd_q, line_odd_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  sl_mode_e sl_act_q, sl_act_d;
  logic     hs_rise, vs_rise;
  stage_t   stage_in;
  stage_t   pipe_q [PIPE];
  stage_t   stage_out;

  always_comb begin
    hs_rise     = hs_in & ~hs_prev_q;
    vs_rise     = vs_in & ~vs_prev_q;
    line_odd_d  = line_odd_q;
    frame_cnt_d = frame_cnt_q;
    sl_act_d    = sl_act_q;
    if (vs_rise) begin
      // Frame start wins over a coincident line start.
      line_odd_d  = 1'b0;
      frame_cnt_d = frame_cnt_q + 16'd1;
      sl_act_d    = sl_mode_e'(sl_mode);
    end else if (hs_rise) begin
      line_odd_d = ~line_odd_q;
    end
  end

  // Parity and mode are resolved per input pixel (including an edge in this
  // same cycle) and travel down the pipeline so darkening matches the pixel.
  always_comb begin
    stage_in.r      = r_in;
    stage_in.g      = g_in;
    stage_in.b      = b_in;
    stage_in.sig.hs = hs_in;
    stage_in.sig.vs = vs_in;
    stage_in.sig.de = de_in;
    stage_in.dark   = line_odd_d ? sl_act_d : SlOff;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      hs_prev_q   <= 1'b0;
      vs_prev_q   <= 1'b0;
      line_odd_q  <= 1'b0;
      frame_cnt_q <= 16'd0;
      sl_act_q    <= SlOff;
      for (int unsigned i = 0; i < PIPE; i++) begin
        pipe_q[i] <= '0;
      end
    end else if (ce_pix) begin
      hs_prev_q   <= hs_in;
      vs_prev_q   <= vs_in;
      line_odd_q  <= line_odd_d;
      frame_cnt_q <= frame_cnt_d;
      sl_act_q    <= sl_act_d;
      pipe_q[0]   <= stage_in;
      for (int unsigned i = 1; i < PIPE; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign stage_out = pipe_q[PIPE-1];

  video_out_fmt_chan_expand #(.IN_W(IN_W), .OUT_W(OUT_W)) u_exp_r (
    .color_i (stage_out.r),
    .de_i    (stage_out.sig.de),
    .dark_i  (stage_out.dark),
    .color_o (VGA_R)
  );

  video_out_fmt_chan_expand #(.IN_W(IN_W), .OUT_W(OUT_W)) u_exp_g (
    .color_i (stage_out.g),
    .de_i    (stage_out.sig.de),
    .dark_i  (stage_out.dark),
    .color_o (VGA_G)
  );

  video_out_fmt_chan_expand #(.IN_W(IN_W), .OUT_W(OUT_W)) u_exp_b (
    .color_i (stage_out.b),
    .de_i    (stage_out.sig.de),
    .dark_i  (stage_out.dark),
    .color_o (VGA_B)
  );

  // Cleared pipeline (sync 0) yields the inactive level.
  assign VGA_HS    = stage_out.sig.hs ^ ~HS_POL;
  assign VGA_VS    = stage_out.sig.vs ^ ~VS_POL;
  assign VGA_DE    = stage_out.sig.de;
  assign line_odd  = line_odd_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_video_out_fmt.sv
module tb_video_out_fmt;

  localparam int unsigned IN_W   = 3;
  localparam int unsigned OUT_W  = 8;
  localparam int unsigned PIPE   = 2;
  localparam bit          HS_POL = 1'b0;
  localparam bit          VS_POL = 1'b1;

  logic             clk_sys = 1'b0;
  logic             rst_n;
  logic             ce_pix;
  logic [IN_W-1:0]  r_in, g_in, b_in;
  logic             hs_in, vs_in, de_in;
  logic [1:0]       sl_mode;
  logic [OUT_W-1:0] VGA_R, VGA_G, VGA_B;
  logic             VGA_HS, VGA_VS, VGA_DE;
  logic             line_odd;
  logic [15:0]      frame_cnt;

  video_out_fmt #(
    .IN_W(IN_W), .OUT_W(OUT_W), .PIPE(PIPE), .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) dut (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .ce_pix    (ce_pix),
    .r_in      (r_in),
    .g_in      (g_in),
    .b_in      (b_in),
    .hs_in     (hs_in),
    .vs_in     (vs_in),
    .de_in     (de_in),
    .sl_mode   (sl_mode),
    .VGA_R     (VGA_R),
    .VGA_G     (VGA_G),
    .VGA_B     (VGA_B),
    .VGA_HS    (VGA_HS),
    .VGA_VS    (VGA_VS),
    .VGA_DE    (VGA_DE),
    .line_odd  (line_odd),
    .frame_cnt (frame_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame/line bookkeeping plus a queue of expected outputs.
  typedef struct {
    int r, g, b;
    bit de, hs, vs;
  } exp_t;

  exp_t exp_q[$];
  bit   m_hs_prev, m_vs_prev, m_odd;
  int   m_frame, m_sl;

  function automatic int expand(input int c);
    int v = 0;
    for (int i = 0; i < int'(OUT_W); i++) begin
      v = v * 2 + ((c >> (int'(IN_W) - 1 - (i % int'(IN_W)))) & 1);
    end
    return v;
  endfunction

  function automatic int darken(input int c, input int mode);
    case (mode)
      1:       return c - c / 4;
      2:       return c / 2;
      3:       return c / 4;
      default: return c;
    endcase
  endfunction

  task automatic model_reset();
    exp_t blank;
    blank = '{r: 0, g: 0, b: 0, de: 0, hs: 0, vs: 0};
    exp_q.delete();
    for (int i = 0; i < int'(PIPE); i++) exp_q.push_back(blank);
    m_hs_prev = 0;
    m_vs_prev = 0;
    m_odd     = 0;
    m_frame   = 0;
    m_sl      = 0;
  endtask

  task automatic model_edge();
    exp_t e;
    exp_t old;
    bit hs_r, vs_r;
    int mode;
    hs_r = hs_in && !m_hs_prev;
    vs_r = vs_in && !m_vs_prev;
    if (vs_r) begin
      m_odd   = 0;
      m_frame = (m_frame + 1) % 65536;
      m_sl    = int'(sl_mode);
    end else if (hs_r) begin
      m_odd = !m_odd;
    end
    m_hs_prev = hs_in;
    m_vs_prev = vs_in;
    mode = m_odd ? m_sl : 0;
    e.de = de_in;
    e.hs = hs_in;
    e.vs = vs_in;
    e.r  = de_in ? darken(expand(int'(r_in)), mode) : 0;
    e.g  = de_in ? darken(expand(int'(g_in)), mode) : 0;
    e.b  = de_in ? darken(expand(int'(b_in)), mode) : 0;
    exp_q.push_back(e);
    old = exp_q.pop_front();
  endtask

  task automatic check_outputs();
    exp_t e;
    e = exp_q[0];
    check_val("vga_r", 32'(VGA_R), 32'(e.r));
    check_val("vga_g", 32'(VGA_G), 32'(e.g));
    check_val("vga_b", 32'(VGA_B), 32'(e.b));
    check_val("vga_de", 32'(VGA_DE), 32'(e.de));
    check_val("vga_hs", 32'(VGA_HS), 32'(e.hs ? HS_POL : !HS_POL));
    check_val("vga_vs", 32'(VGA_VS), 32'(e.vs ? VS_POL : !VS_POL));
    check_val("line_odd", 32'(line_odd), 32'(m_odd));
    check_val("frame_cnt", 32'(frame_cnt), 32'(m_frame));
  endtask

  // One clock: model follows the DUT edge, outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk_sys);
    if (ce_pix && rst_n) model_edge();
    #1;
    check_outputs();
  endtask

  initial begin
    rst_n = 1'b0;
    ce_pix = 1'b0;
    {r_in, g_in, b_in} = '0;
    {hs_in, vs_in, de_in} = '0;
    sl_mode = 2'd0;
    model_reset();
    #2;
    check_outputs();
    check_val("rst_hs_inactive", 32'(VGA_HS), 32'(!HS_POL));
    check_val("rst_vs_inactive", 32'(VGA_VS), 32'(!VS_POL));
    #10;
    rst_n = 1'b1;

    // Sync already high on the first enabled cycle counts as an edge.
    ce_pix = 1'b1;
    hs_in = 1'b1;
    tick();
    check_val("first_hs_edge", 32'(line_odd), 32'd1);
    hs_in = 1'b0;

    // Expansion.
    de_in = 1'b1; r_in = 3'b101; g_in = 3'b111; b_in = 3'b000;
    tick(); tick();
    check_val("expand_r", 32'(VGA_R), 32'hB6);
    check_val("expand_g", 32'(VGA_G), 32'hFF);
    check_val("expand_b", 32'(VGA_B), 32'h00);

    // Blanking and sync polarity.
    de_in = 1'b0; r_in = 3'h7; g_in = 3'h7; b_in = 3'h7; hs_in = 1'b1;
    tick(); tick();
    check_val("blank_r", 32'(VGA_R), 32'h00);
    check_val("hs_active_low", 32'(VGA_HS), 32'd0);

    // Scanlines at 50%.
    de_in = 1'b1; hs_in = 1'b0; vs_in = 1'b1; sl_mode = 2'd2;
    tick();
    vs_in = 1'b0;
    tick(); tick();
    check_val("sl_even", 32'(VGA_R), 32'hFF);
    hs_in = 1'b1;
    tick(); tick();
    check_val("sl_odd", 32'(VGA_R), 32'h7F);

    // Mid-frame mode change is ignored until the next frame.
    sl_mode = 2'd3;
    tick(); tick();
    check_val("midframe_hold", 32'(VGA_R), 32'h7F);
    hs_in = 1'b0; vs_in = 1'b1;
    tick();
    vs_in = 1'b0; hs_in = 1'b1;
    tick(); tick();
    check_val("sl_new_frame", 32'(VGA_R), 32'h3F);

    // Simultaneous hs/vs rise.
    hs_in = 1'b0; vs_in = 1'b0;
    tick(); tick();
    hs_in = 1'b1; vs_in = 1'b1;
    tick();
    check_val("simul_edges", 32'(line_odd), 32'd0);
    hs_in = 1'b0; vs_in = 1'b0;
    tick();

    // Frame counter wrap.
    ce_pix = 1'b0;
    force dut.frame_cnt_q = 16'hFFFF;
    m_frame = 16'hFFFF;
    tick();
    release dut.frame_cnt_q;
    tick();
    ce_pix = 1'b1; vs_in = 1'b1;
    tick();
    check_val("frame_wrap", 32'(frame_cnt), 32'd0);
    vs_in = 1'b0;

    // ce_pix gap: everything freezes while inputs wander.
    de_in = 1'b1; r_in = 3'd3; g_in = 3'd4; b_in = 3'd6;
    tick(); tick();
    ce_pix = 1'b0;
    for (int i = 0; i < 5; i++) begin
      r_in = 3'($urandom); hs_in = ~hs_in; vs_in = ~vs_in; de_in = ~de_in;
      tick();
    end
    check_val("gap_frozen_r", 32'(VGA_R), 32'(expand(3)));
    {hs_in, vs_in} = 2'b00;
    de_in = 1'b1;
    ce_pix = 1'b1;
    tick(); tick();

    // Asynchronous reset mid-line.
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check_val("rst_async_de", 32'(VGA_DE), 32'd0);
    tick();
    #3 rst_n = 1'b1;
    r_in = 3'h7;
    tick();
    check_val("post_rst_blank", 32'(VGA_DE), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      ce_pix = ($urandom_range(0, 3) != 0);
      de_in  = ($urandom_range(0, 4) != 0);
      r_in   = 3'($urandom);
      g_in   = 3'($urandom);
      b_in   = 3'($urandom);
      if ($urandom_range(0, 5) == 0)  hs_in = ~hs_in;
      if ($urandom_range(0, 40) == 0) vs_in = ~vs_in;
      if ($urandom_range(0, 30) == 0) sl_mode = 2'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk_sys);
        #1;
        check_outputs();
        #2 rst_n = 1'b1;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
